// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the unified memory controller.
//   - controller FSM state encoding
//   - latency counter width
//   - default word width and boolean constants
package mem_ctrl_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned MEMC_CNT_W = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        MEMC_IDLE  = 2'd0,
        MEMC_D_ACC = 2'd1,
        MEMC_I_ACC = 2'd2,
        MEMC_DONE  = 2'd3
    } memc_state_e;

endpackage

// File: rtl/mem_ctrl_lat_counter.sv
// RAM read-latency counter.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : clear the count to 0 on the next edge (wins over enable)
//   enable     : advance the count by one per cycle, saturating at LAT
//   hit        : count == LAT (read data is on ram_rdata this cycle)
module memc_lat_counter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic enable,
    output logic hit
);

    logic [MEMC_CNT_W-1:0] cnt_q;
    logic [MEMC_CNT_W-1:0] cnt_d;

    assign hit = (cnt_q == MEMC_CNT_W'(LAT));

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (enable && !hit) begin
            cnt_d = cnt_q + MEMC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Unified memory controller: serializes the core's data access (priority)
// and instruction fetch onto one single-ported fixed-latency word RAM.
//   clk, rst                      : clock, asynchronous active-low reset
//   pc / inst                     : fetch byte address in, registered instruction out
//   load_en, l_addr / l_data      : load request, registered loaded word out
//   store_en, s_addr, s_data, s_be: store request
//   stall                         : core holds its pipeline while high
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_be, ram_rdata  : RAM port (read data LAT cycles after ram_en)
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned W      = WORD_WIDTH,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      pc,
    output logic [W-1:0]      inst,
    input  logic              load_en,
    input  logic [W-1:0]      l_addr,
    output logic [W-1:0]      l_data,
    input  logic              store_en,
    input  logic [W-1:0]      s_addr,
    input  logic [W-1:0]      s_data,
    input  logic [3:0]        s_be,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [W-1:0]      ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [W-1:0]      ram_rdata
);

    memc_state_e       state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [ADDR_W-1:0] pc_word_q, pc_word_d;
    logic [ADDR_W-1:0] d_word_q, d_word_d;
    logic [W-1:0]      s_data_q, s_data_d;
    logic [3:0]        s_be_q, s_be_d;
    logic [W-1:0]      inst_q, inst_d;
    logic [W-1:0]      l_data_q, l_data_d;
    logic              issue_q, issue_d;
    logic              ld_gap_q, ld_gap_d;

    logic cnt_start;
    logic cnt_en;
    logic cnt_hit;

    // Byte offset and bits above the RAM depth are intentionally discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc, l_addr, s_addr};

    memc_lat_counter #(
        .LAT (LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .start  (cnt_start),
        .enable (cnt_en),
        .hit    (cnt_hit)
    );

    // Next state, request latching and capture registers.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        pc_word_d  = pc_word_q;
        d_word_d   = d_word_q;
        s_data_d   = s_data_q;
        s_be_d     = s_be_q;
        inst_d     = inst_q;
        l_data_d   = l_data_q;
        issue_d    = FALSE;
        ld_gap_d   = FALSE;
        cnt_start  = FALSE;
        cnt_en     = FALSE;

        unique case (state_q)
            MEMC_IDLE: begin
                // A simultaneous load is dropped: the store wins the data slot.
                is_store_d = store_en;
                pc_word_d  = pc[ADDR_W+1:2];
                d_word_d   = store_en ? s_addr[ADDR_W+1:2] : l_addr[ADDR_W+1:2];
                s_data_d   = s_data;
                s_be_d     = s_be;
                cnt_start  = TRUE;
                issue_d    = TRUE;
                state_d    = (store_en || load_en) ? MEMC_D_ACC : MEMC_I_ACC;
            end

            MEMC_D_ACC: begin
                if (is_store_q || ld_gap_q) begin
                    cnt_start = TRUE;
                    issue_d   = TRUE;
                    state_d   = MEMC_I_ACC;
                end else if (cnt_hit) begin
                    // One dead cycle follows the load capture before the
                    // fetch is issued, giving the 2*LAT+5 load step.
                    l_data_d  = ram_rdata;
                    cnt_start = TRUE;
                    ld_gap_d  = TRUE;
                end else begin
                    cnt_en = TRUE;
                end
            end

            MEMC_I_ACC: begin
                if (cnt_hit) begin
                    inst_d    = ram_rdata;
                    cnt_start = TRUE;
                    state_d   = MEMC_DONE;
                end else begin
                    cnt_en = TRUE;
                end
            end

            MEMC_DONE: begin
                state_d = MEMC_IDLE;
            end

            default: begin
                state_d = MEMC_IDLE;
            end
        endcase
    end

    // RAM port: issue_q marks the single strobe cycle of each access.
    always_comb begin
        ram_en    = issue_q;
        ram_we    = issue_q && (state_q == MEMC_D_ACC) && is_store_q;
        ram_addr  = '0;
        if (issue_q) begin
            ram_addr = (state_q == MEMC_I_ACC) ? pc_word_q : d_word_q;
        end
        ram_wdata = ram_we ? s_data_q : '0;
        ram_be    = ram_we ? s_be_q : '0;
        stall     = (state_q != MEMC_DONE);
    end

    assign inst   = inst_q;
    assign l_data = l_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MEMC_IDLE;
            is_store_q <= 1'b0;
            pc_word_q  <= '0;
            d_word_q   <= '0;
            s_data_q   <= '0;
            s_be_q     <= '0;
            inst_q     <= '0;
            l_data_q   <= '0;
            issue_q    <= 1'b0;
            ld_gap_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            pc_word_q  <= pc_word_d;
            d_word_q   <= d_word_d;
            s_data_q   <= s_data_d;
            s_be_q     <= s_be_d;
            inst_q     <= inst_d;
            l_data_q   <= l_data_d;
            issue_q    <= issue_d;
            ld_gap_q   <= ld_gap_d;
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Unified memory controller between the pipelined `cpu` core and a single-ported, fixed-latency word RAM. It serializes the core's instruction fetch (`pc`) and data load/store requests onto one RAM port, with data taking priority. It registers fetched instructions and loaded words. It holds the core with `stall` until every access for the current cycle has completed.

## Interface
Parameters:
- `W`, `` `WORD_WIDTH `` (32): data/address width.
- `ADDR_W`, 16: RAM word-address width (depth 2^ADDR_W words).
- `LAT`, 2: RAM read latency in cycles, legal range 1..15.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc`  in  W  byte address of instruction fetch, sampled in IDLE.
- `inst`  out  W  registered fetched instruction.
- `load_en`  in  1  data load request.
- `l_addr`  in  W  load byte address.
- `l_data`  out  W  registered loaded word.
- `store_en`  in  1  data store request.
- `s_addr`  in  W  store byte address.
- `s_data`  in  W  store data.
- `s_be`  in  4  store byte enables.
- `stall`  out  1  core must hold all pipeline registers while high.
- `ram_en`  out  1  RAM access strobe, one cycle per access.
- `ram_we`  out  1  write qualifier for `ram_en`.
- `ram_addr`  out  ADDR_W  word address.
- `ram_wdata`  out  W  write data.
- `ram_be`  out  4  write byte enables.
- `ram_rdata`  in  W  read data, valid exactly LAT cycles after the `ram_en` cycle.

## Operation
- FSM states:
  - IDLE: decide; latch request, addresses, store data.
  - D_ACC: data access.
  - I_ACC: instruction access.
  - DONE: release.
- IDLE -> D_ACC if `store_en|load_en`; otherwise IDLE -> I_ACC.
- D_ACC, store: `ram_en=ram_we=1` for 1 cycle, then -> I_ACC.
- D_ACC, load: `ram_en=1, ram_we=0` in the first cycle. A counter runs 0..LAT. `l_data <= ram_rdata` when the counter reaches LAT, then -> I_ACC.
- I_ACC: read at `pc`; `inst <= ram_rdata` when the counter reaches LAT, then -> DONE.
- DONE: `stall=0` for exactly 1 cycle, then -> IDLE. The core advances on the edge ending DONE.
- `stall=1` in every state except DONE.
- `ram_addr = addr[ADDR_W+1:2]`. Byte offset bits are ignored, so misaligned accesses are word-aligned. Upper bits are dropped, so addresses wrap modulo RAM size.
- `load_en` and `store_en` both high: the store is performed, the load is ignored, and `l_data` is unchanged.
- `ram_we`, `ram_be`, and `ram_wdata` are 0 whenever `ram_en=0` or the access is a read.
- `l_data` and `inst` change only at their capture edges. They are stable throughout DONE and IDLE.
- Requests are sampled only in IDLE. Input changes in other states are ignored.

## Timing
- Reset (`rst=0`, asynchronous):
  - State goes to IDLE.
  - `inst` = 0 (NOP).
  - `l_data`, `ram_*` outputs, and counter = 0.
  - `stall` = 1.
- Reset mid-access abandons the access, and the RAM response is discarded. After release, the first IDLE occurs on the first edge.
- Cycles per core step, from IDLE to the end of DONE:
  - fetch only: LAT+3
  - fetch + store: LAT+4
  - fetch + load: 2·LAT+5
- With LAT=2 these are 5, 6, and 9 cycles respectively.
- `ram_en` is high for exactly one cycle per access. It is never asserted in IDLE or DONE.

## Structure
- Shared package `defines.v`:
  - state encodings `` `MEMC_IDLE ``, `` `MEMC_D_ACC ``, `` `MEMC_I_ACC ``, `` `MEMC_DONE ``
  - `` `MEMC_CNT_W `` (4)
  - reuse `` `WORD_WIDTH ``, `` `TRUE ``, `` `FALSE ``
- One sub-module, `memc_lat_counter`:
  - inputs: start, enable
  - output: `hit` when count == LAT
  - async active-low reset
- The FSM, address mux, and capture registers live in `mem_ctrl`.

## Test plan
- Reset, then release with `pc=0x0`, no data request and RAM[0]=0x2408_0005:
  - `stall` is 1 for 4 cycles, then 0 for 1 cycle with `inst`=0x2408_0005.
  - One `ram_en` pulse with `ram_addr`=0.
- Load: `l_addr`=0x104, RAM[0x41]=0xDEAD_BEEF, `pc`=0x8:
  - First `ram_en` has `ram_addr`=0x41 and `ram_we`=0.
  - Second `ram_en` has `ram_addr`=0x2.
  - `l_data`=0xDEAD_BEEF and `stall` low exactly in cycle 9.
- Store: `s_addr`=0x20, `s_data`=0x1234_5678, `s_be`=4'b0011:
  - One write with `ram_addr`=0x8, `ram_be`=0011, `ram_we`=1.
  - Then the fetch.
  - `stall` low in cycle 6.
- Simultaneous `load_en`+`store_en`, with `l_data` previously 0xAAAA_AAAA:
  - Only the store is issued.
  - `l_data` remains 0xAAAA_AAAA.
- Address edges:
  - `l_addr`=0x0004_0003 → `ram_addr`=0x0000 (offset ignored, wrap at ADDR_W=16).
  - `pc`=0x3_FFFC → `ram_addr`=0xFFFF.
- Assert `rst` during I_ACC with the counter at 1:
  - `stall`=1, `ram_en`=0, `inst`=0 immediately.
  - The late `ram_rdata` is not captured.
  - A normal fetch completes after release.
